// File: rtl/layer_mixer_pkg.sv
// mixer_pkg: shared sizes, config FSM states, identity table and priority resolve
package mixer_pkg;
  localparam int N_LAYERS = 4;
  localparam int LAYER_W = 2;
  typedef enum logic {IDLE, PENDING} cfg_state_t;
  typedef logic [N_LAYERS*LAYER_W-1:0] prio_t;
  function automatic prio_t identity_prio();
    prio_t p;
    for (int k = 0; k < N_LAYERS; k++) p[k*LAYER_W +: LAYER_W] = LAYER_W'(k);
    return p;
  endfunction
  localparam prio_t IDENTITY_PRIO = identity_prio();
  // returns {hit, layer}; scanning from the lowest priority upward lets slot 0 override last
  function automatic logic [LAYER_W:0] resolve(input logic [N_LAYERS-1:0] flags,
                                               input logic [N_LAYERS-1:0] en,
                                               input prio_t prio);
    logic [LAYER_W:0] win;
    logic [LAYER_W-1:0] idx;
    win = '0;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      idx = prio[k*LAYER_W +: LAYER_W];
      if (flags[idx] && en[idx]) win = {1'b1, idx};
    end
    return win;
  endfunction
endpackage

// File: rtl/layer_mixer_if.sv
// layer_mixer_if: pixel stream, layer inputs, config handshake and mixed output
interface layer_mixer_if;
  import mixer_pkg::*;
  logic [9:0] x_pos;
  logic [8:0] y_pos;
  logic de;
  logic [N_LAYERS-1:0] rq_flags;
  logic [24*N_LAYERS-1:0] rgb_in;
  logic cfg_valid;
  logic cfg_ready;
  prio_t cfg_prio;
  logic [N_LAYERS-1:0] cfg_en;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic de_out;
  logic [LAYER_W-1:0] layer_sel;
  logic layer_hit;
  logic frame_start;
  modport slave (input x_pos, y_pos, de, rq_flags, rgb_in, cfg_valid, cfg_prio, cfg_en,
                 output cfg_ready, r, g, b, de_out, layer_sel, layer_hit, frame_start);
  modport master (output x_pos, y_pos, de, rq_flags, rgb_in, cfg_valid, cfg_prio, cfg_en,
                  input cfg_ready, r, g, b, de_out, layer_sel, layer_hit, frame_start);
endinterface

// File: rtl/layer_mixer_pipe_delay.sv
// pipe_delay: fixed-depth shift register with sync reset to zero
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sr_q [DEPTH];
  // shift one stage per clock, flush on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/layer_mixer.sv
// layer_mixer: priority-mixes display layers with a frame-synchronous priority/enable table
module layer_mixer
  import mixer_pkg::*;
#(
  parameter int ROM_LAT = 1,
  parameter logic [23:0] DEF_COLOR = 24'h000000
) (
  input logic pixel_clk,
  input logic rst,
  layer_mixer_if.slave bus
);
  cfg_state_t state_q, state_d;
  prio_t sh_prio_q, sh_prio_d, act_prio_q, act_prio_d, eff_prio, prio_dl;
  logic [N_LAYERS-1:0] sh_en_q, sh_en_d, act_en_q, act_en_d, eff_en, en_dl, flags_dl;
  logic fs_q, fs_d, de_dl, boundary, commit;
  logic [LAYER_W:0] res;
  logic [23:0] win_rgb, pix_d, pix_q;
  logic de_out_q, hit_d, hit_q;
  logic [LAYER_W-1:0] sel_d, sel_q;
  assign boundary = bus.x_pos == 10'd0 && bus.y_pos == 9'd0;
  assign commit = state_q == PENDING && boundary;
  // the pixel at (0,0) already sees the committed table, so bypass the active copy on commit
  assign eff_prio = commit ? sh_prio_q : act_prio_q;
  assign eff_en = commit ? sh_en_q : act_en_q;
  // config FSM: capture into shadow when idle, swap into active at the next frame origin
  always_comb begin
    state_d = state_q;
    sh_prio_d = sh_prio_q;
    sh_en_d = sh_en_q;
    act_prio_d = act_prio_q;
    act_en_d = act_en_q;
    fs_d = 1'b0;
    if (state_q == IDLE && bus.cfg_valid) begin
      state_d = PENDING;
      sh_prio_d = bus.cfg_prio;
      sh_en_d = bus.cfg_en;
    end
    if (commit) begin
      state_d = IDLE;
      act_prio_d = sh_prio_q;
      act_en_d = sh_en_q;
      fs_d = 1'b1;
    end
  end
  // config state and table registers
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_prio_q <= IDENTITY_PRIO;
      sh_en_q <= '1;
      act_prio_q <= IDENTITY_PRIO;
      act_en_q <= '1;
      fs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_prio_q <= sh_prio_d;
      sh_en_q <= sh_en_d;
      act_prio_q <= act_prio_d;
      act_en_q <= act_en_d;
      fs_q <= fs_d;
    end
  end
  pipe_delay #(.WIDTH(2*N_LAYERS + 1 + N_LAYERS*LAYER_W), .DEPTH(ROM_LAT)) u_align (
    .clk(pixel_clk),
    .rst(rst),
    .d_i({bus.rq_flags, bus.de, eff_prio, eff_en}),
    .q_o({flags_dl, de_dl, prio_dl, en_dl})
  );
  assign res = resolve(flags_dl, en_dl, prio_dl);
  assign win_rgb = bus.rgb_in[24*res[LAYER_W-1:0] +: 24];
  assign hit_d = de_dl && res[LAYER_W];
  assign sel_d = hit_d ? res[LAYER_W-1:0] : '0;
  assign pix_d = !de_dl ? 24'h0 : res[LAYER_W] ? win_rgb : DEF_COLOR;
  // registered output stage
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      pix_q <= '0;
      de_out_q <= 1'b0;
      sel_q <= '0;
      hit_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      de_out_q <= de_dl;
      sel_q <= sel_d;
      hit_q <= hit_d;
    end
  end
  assign {bus.r, bus.g, bus.b} = pix_q;
  assign bus.de_out = de_out_q;
  assign bus.layer_sel = sel_q;
  assign bus.layer_hit = hit_q;
  assign bus.frame_start = fs_q;
  assign bus.cfg_ready = state_q == IDLE;
endmodule

// File: tb/tb_layer_mixer.sv
// tb_layer_mixer: directed and random pixel streams checked against a frame-level table model
module tb_layer_mixer;
  localparam int LAT = 2;
  localparam logic [23:0] DEF = 24'h123456;
  localparam logic [7:0] ID_P = 8'hE4;
  localparam logic [7:0] SWAP_P = 8'h1E;
  typedef struct {
    bit chk;
    logic [24:0] pix;
    logic [2:0] hs;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_a [0:2047];
  logic [95:0] rgb_a [0:2047];
  int m_prio [4];
  int s_prio [4];
  logic [3:0] m_en, s_en;
  bit m_pend, fs_exp;
  layer_mixer_if bus ();
  layer_mixer #(.ROM_LAT(1), .DEF_COLOR(DEF)) dut (.pixel_clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_prio[k] = k;
    m_en = 4'hF;
    m_pend = 0;
    fs_exp = 0;
  endtask
  task automatic step(input logic r_i, input logic [9:0] x, input logic [8:0] y, input logic d,
                      input logic [3:0] fl, input logic [95:0] rgbv, input logic cv,
                      input logic [7:0] cp, input logic [3:0] ce);
    int tp [4];
    logic [3:0] te;
    bit hit, bnd;
    int sel;
    if (cyc >= LAT && exp_a[cyc-LAT].chk) begin
      checks++;
      assert ({bus.de_out, bus.r, bus.g, bus.b} === exp_a[cyc-LAT].pix) else begin
        errors++;
        $error("FAIL pix cyc=%0d got %h exp %h", cyc, {bus.de_out, bus.r, bus.g, bus.b}, exp_a[cyc-LAT].pix);
      end
      checks++;
      assert ({bus.layer_hit, bus.layer_sel} === exp_a[cyc-LAT].hs) else begin
        errors++;
        $error("FAIL hit_sel cyc=%0d got %b exp %b", cyc, {bus.layer_hit, bus.layer_sel}, exp_a[cyc-LAT].hs);
      end
    end
    if (cyc >= 1) begin
      checks++;
      assert (bus.cfg_ready === !m_pend) else begin
        errors++;
        $error("FAIL cfg_ready cyc=%0d got %b exp %b", cyc, bus.cfg_ready, !m_pend);
      end
      checks++;
      assert (bus.frame_start === fs_exp) else begin
        errors++;
        $error("FAIL frame_start cyc=%0d got %b exp %b", cyc, bus.frame_start, fs_exp);
      end
    end
    rst = r_i;
    bus.x_pos = x;
    bus.y_pos = y;
    bus.de = d;
    bus.rq_flags = fl;
    bus.rgb_in = cyc > 0 ? rgb_a[cyc-1] : '0;
    bus.cfg_valid = cv;
    bus.cfg_prio = cp;
    bus.cfg_en = ce;
    rgb_a[cyc] = rgbv;
    if (r_i) begin
      exp_a[cyc] = '{1, '0, '0};
      if (cyc > 0) exp_a[cyc-1] = '{1, '0, '0};
      model_reset();
    end else begin
      bnd = x == 0 && y == 0;
      for (int k = 0; k < 4; k++) tp[k] = (m_pend && bnd) ? s_prio[k] : m_prio[k];
      te = (m_pend && bnd) ? s_en : m_en;
      hit = 0;
      sel = 0;
      for (int k = 0; k < 4; k++)
        if (!hit && fl[tp[k]] && te[tp[k]]) begin
          hit = 1;
          sel = tp[k];
        end
      if (!d) exp_a[cyc] = '{1, '0, '0};
      else exp_a[cyc] = '{1, {1'b1, hit ? rgbv[sel*24 +: 24] : DEF}, {hit, 2'(sel)}};
      fs_exp = 0;
      if (m_pend && bnd) begin
        m_prio = s_prio;
        m_en = s_en;
        m_pend = 0;
        fs_exp = 1;
      end else if (!m_pend && cv) begin
        for (int k = 0; k < 4; k++) s_prio[k] = int'(cp[k*2 +: 2]);
        s_en = ce;
        m_pend = 1;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic px(input logic [9:0] x, input logic [8:0] y, input logic d, input logic [3:0] fl);
    step(0, x, y, d, fl, {$urandom, $urandom, $urandom}, 0, ID_P, 4'hF);
  endtask
  initial begin
    logic [95:0] fixed;
    model_reset();
    fixed = {24'h0000FF, 24'h00FF00, 24'hABCDEF, 24'hFF0000};
    for (int i = 0; i < 3; i++) step(1, 10'd5, 9'd5, 1, 4'h0, fixed, 0, ID_P, 4'hF);
    for (int i = 0; i < 4; i++) step(0, 10'(6 + i), 9'd5, 1, 4'h0, fixed, 0, ID_P, 4'hF);
    for (int i = 0; i < 4; i++) step(0, 10'(20 + i), 9'd5, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    step(0, 10'd30, 9'd7, 1, 4'b0101, fixed, 1, SWAP_P, 4'hF);
    for (int i = 0; i < 4; i++) step(0, 10'(31 + i), 9'd7, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    step(0, 10'd0, 9'd0, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    for (int i = 0; i < 4; i++) step(0, 10'(1 + i), 9'd0, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    step(0, 10'd0, 9'd0, 1, 4'b0101, fixed, 1, ID_P, 4'hF);
    for (int i = 0; i < 4; i++) step(0, 10'(1 + i), 9'd0, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    step(0, 10'd0, 9'd0, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    for (int i = 0; i < 3; i++) step(0, 10'(1 + i), 9'd0, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    step(0, 10'd9, 9'd2, 1, 4'b0001, fixed, 1, ID_P, 4'b1110);
    step(0, 10'd0, 9'd0, 1, 4'b0001, fixed, 0, ID_P, 4'hF);
    for (int i = 0; i < 3; i++) step(0, 10'(1 + i), 9'd0, 1, 4'b0001, fixed, 0, ID_P, 4'hF);
    for (int i = 0; i < 3; i++) step(0, 10'(8 + i), 9'd0, 0, 4'b1111, fixed, 0, ID_P, 4'hF);
    step(0, 10'd9, 9'd2, 1, 4'b0101, fixed, 1, SWAP_P, 4'hF);
    step(0, 10'd10, 9'd2, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    step(1, 10'd11, 9'd2, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    for (int i = 0; i < 3; i++) step(0, 10'(12 + i), 9'd2, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    step(0, 10'd0, 9'd0, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    for (int i = 0; i < 3; i++) step(0, 10'(1 + i), 9'd0, 1, 4'b0101, fixed, 0, ID_P, 4'hF);
    for (int i = 0; i < 600; i++) begin
      logic b0;
      b0 = $urandom_range(0, 7) == 0;
      step($urandom_range(0, 99) == 0, b0 ? 10'd0 : 10'($urandom_range(1, 639)),
           b0 ? 9'd0 : 9'($urandom_range(0, 479)), $urandom_range(0, 3) != 0,
           4'($urandom), {$urandom, $urandom, $urandom}, $urandom_range(0, 5) == 0,
           8'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 3; i++) px(10'(100 + i), 9'd1, 1, 4'b0010);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
